imem_loader_ctrl: RTL and testbench

Controller for the 256x32 instruction memory. Owns the memory's single port and shares it between two requesters: a byte-serial program loader, which writes the program, and the CPU fetch path, which reads it. Holds the CPU idle while loading, then hands the port to fetch. This replaces hard-coded program images with a runtime-loaded program.

---
 rtl/imem_loader_ctrl.sv | 120 ++++++++++++
 tb/tb_imem_loader_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: shares the instruction memory port between a byte-serial loader and CPU fetch
module imem_loader_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);
    typedef enum logic [1:0] {LOAD, WRITE, RUN} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t              state_q;
    logic [1:0]          idx_q;
    logic [WORD_W-1:0]   word_q, word_d, wdata_q, fdata_q;
    logic [ADDR_W:0]     wc_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic                err_q, last_q, ld_ready_q, mem_we_q, cpu_run_q, fv_q, oob_q;
    logic                accept, full;
    always_comb begin
        accept     = state_q == LOAD && ld_ready_q && ld_valid && !reload;
        full       = wc_q == FULL;
        word_d     = (idx_q == 2'd0 ? '0 : word_q) | (WORD_W'(ld_byte) << {~idx_q, 3'b000});
        fetch_data = fv_q ? (oob_q ? '0 : mem_rdata) : fdata_q;
        mem_addr   = (state_q == RUN && fetch_req) ? fetch_addr : waddr_q;
    end
    assign ld_ready    = ld_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = wdata_q;
    assign cpu_run     = cpu_run_q;
    assign fetch_valid = fv_q;
    assign word_count  = wc_q;
    assign error       = err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            word_q     <= '0;
            wdata_q    <= '0;
            fdata_q    <= '0;
            wc_q       <= '0;
            waddr_q    <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            ld_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_run_q  <= 1'b0;
            fv_q       <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            fv_q     <= state_q == RUN && fetch_req;
            oob_q    <= {1'b0, fetch_addr} >= wc_q || {1'b0, fetch_addr} >= FULL;
            fdata_q  <= fetch_data;
            case (state_q)
                LOAD: begin
                    ld_ready_q <= 1'b1;
                    if (reload) begin
                        idx_q <= '0;
                        wc_q  <= '0;
                        err_q <= 1'b0;
                    end else if (accept && full) begin
                        // memory is full: drop the byte but still honour end of program
                        err_q <= 1'b1;
                        if (ld_last) begin
                            state_q    <= RUN;
                            ld_ready_q <= 1'b0;
                            cpu_run_q  <= 1'b1;
                        end
                    end else if (accept) begin
                        word_q <= word_d;
                        idx_q  <= idx_q + 2'd1;
                        if (idx_q == 2'd3 || ld_last) begin
                            state_q    <= WRITE;
                            ld_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            waddr_q    <= wc_q[ADDR_W-1:0];
                            wdata_q    <= word_d;
                            last_q     <= ld_last;
                            idx_q      <= '0;
                        end
                    end
                end
                WRITE: begin
                    wc_q       <= reload ? '0 : wc_q + (ADDR_W+1)'(1);
                    err_q      <= reload ? 1'b0 : err_q;
                    state_q    <= (last_q && !reload) ? RUN : LOAD;
                    ld_ready_q <= !last_q || reload;
                    cpu_run_q  <= last_q && !reload;
                end
                RUN: begin
                    if (reload) begin
                        state_q    <= LOAD;
                        ld_ready_q <= 1'b1;
                        cpu_run_q  <= 1'b0;
                        wc_q       <= '0;
                        err_q      <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: scoreboard bench with a byte-stream reference model and a memory model
module tb_imem_loader_ctrl;
    logic        clk = 0, rst_n = 0, ld_valid = 0, ld_last = 0, reload = 0, fetch_req = 0;
    logic [7:0]  ld_byte = 0, fetch_addr = 0;
    logic        ld_ready, fetch_valid, cpu_run, mem_we, error;
    logic [31:0] fetch_data, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [8:0]  word_count;

    imem_loader_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .reload(reload), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .cpu_run(cpu_run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .word_count(word_count), .error(error)
    );

    int          tests = 0, fails = 0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [39:0] exp_wr [$];
    logic [31:0] exp_fd [$];
    logic [7:0]  cur [$];
    int          wc_m = 0;
    bit          err_m = 0;
    logic [31:0] last_fd = 0;
    logic [39:0] e_wr;
    logic [31:0] e_fd;

    always #5 clk = ~clk;

    // synchronous single-port instruction memory, contents survive reset
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write at %0t", mem_addr, mem_wdata, $time);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("write", {mem_addr, mem_wdata}, e_wr);
            end
        end
        if (fetch_valid) begin
            if (exp_fd.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_fetch: got data 0x%0h, expected no fetch_valid at %0t", fetch_data, $time);
            end else begin
                e_fd = exp_fd.pop_front();
                chk("fetch_data", fetch_data, e_fd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input int a);
        return (a < wc_m) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit last, output bit wrote);
        logic [31:0] w;
        wrote = 0;
        if (wc_m == 256) err_m = 1;
        else begin
            cur.push_back(b);
            if (cur.size() == 4 || last) begin
                w = 0;
                for (int i = 0; i < 4; i++) w = {w[23:0], (i < cur.size()) ? cur[i] : 8'h00};
                exp_wr.push_back({8'(wc_m), w});
                ref_mem[wc_m] = w;
                wc_m++;
                cur.delete();
                wrote = 1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n = 0;
        bit wrote;
        ld_valid = 1; ld_byte = b; ld_last = last;
        while (!ld_ready && n < 10) begin tick(); n++; end
        if (!ld_ready) begin
            tests++; fails++;
            $display("FAIL ld_ready_timeout: got ld_ready=%0b, expected 1 within 10 cycles", ld_ready);
        end
        tick();
        ld_valid = 0; ld_last = 0;
        model_byte(b, last, wrote);
        chk("error", error, err_m);
        if (last) begin
            if (wrote) begin
                chk("cpu_run_during_write", cpu_run, 0);
                tick();
            end
            chk("cpu_run", cpu_run, 1);
            chk("word_count", word_count, wc_m);
            chk("ld_ready_in_run", ld_ready, 0);
        end
    endtask

    task automatic load_seq(input logic [7:0] bs [$], input int maxgap);
        for (int i = 0; i < bs.size(); i++) begin
            send_byte(bs[i], i == bs.size() - 1);
            if (maxgap > 0 && i < bs.size() - 1) repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic load_random(input int len, input int maxgap);
        logic [7:0] q [$];
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        load_seq(q, maxgap);
    endtask

    task automatic fetch_burst(input logic [7:0] addrs [$], input bit b2b);
        foreach (addrs[i]) begin
            fetch_req = 1; fetch_addr = addrs[i];
            last_fd = exp_word(int'(addrs[i]));
            exp_fd.push_back(last_fd);
            tick();
            if (b2b) continue;
            fetch_req = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
        fetch_req = 0;
        tick(); tick();
        chk("fetch_idle", fetch_valid, 0);
        chk("fetch_hold", fetch_data, last_fd);
    endtask

    task automatic fetch_random(input int n, input bit b2b);
        logic [7:0] q [$];
        int hi;
        hi = (wc_m + 2 > 255) ? 255 : wc_m + 2;
        for (int i = 0; i < n; i++) q.push_back(($urandom % 5 == 0) ? 8'hFF : 8'($urandom_range(0, hi)));
        fetch_burst(q, b2b);
    endtask

    task automatic do_reload(input bit with_fetch);
        reload = 1;
        if (with_fetch) begin
            fetch_req = 1;
            fetch_addr = 8'($urandom_range(0, 3));
            last_fd = exp_word(int'(fetch_addr));
            exp_fd.push_back(last_fd);
        end
        tick();
        reload = 0; fetch_req = 0;
        wc_m = 0; err_m = 0; cur.delete();
        if (with_fetch) chk("reload_fetch_valid", fetch_valid, 1);
        chk("reload_cpu_run", cpu_run, 0);
        chk("reload_word_count", word_count, 0);
        chk("reload_error", error, 0);
        chk("reload_ld_ready", ld_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t1 [8] = '{8'h0C, 8'h01, 8'h00, 8'h03, 8'h04, 8'h01, 8'h00, 8'h04};
        logic [7:0] q [$];
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = 0; end
        rst_n = 0;
        repeat (3) tick();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_error", error, 0);
        rst_n = 1;
        // two-word program, then fetch both words and one unloaded word
        foreach (t1[i]) q.push_back(t1[i]);
        load_seq(q, 0);
        chk("t1_word_count", word_count, 2);
        q = {};
        q.push_back(8'd0); q.push_back(8'd1); q.push_back(8'd2);
        fetch_burst(q, 1);
        do_reload(1);
        // partial word is zero-padded in its low bytes
        q = {};
        q.push_back(8'hAA); q.push_back(8'hBB);
        load_seq(q, 0);
        chk("t3_word_count", word_count, 1);
        // reload while a partial word is pending discards it
        do_reload(0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reload(0);
        load_random(4, 1);
        fetch_random(4, 1);
        // overflow: 257th word onward is dropped and flagged
        do_reload(0);
        load_random(1028, 0);
        chk("ovf_word_count", word_count, 256);
        chk("ovf_error", error, 1);
        fetch_random(8, 1);
        for (int r = 0; r < 6; r++) begin
            do_reload(r[0]);
            load_random($urandom_range(1, 40), 2);
            fetch_random(6, r[1]);
        end
        // reset in the middle of a word
        do_reload(0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        rst_n = 0;
        tick(); tick();
        wc_m = 0; err_m = 0; cur.delete();
        chk("t6_word_count", word_count, 0);
        chk("t6_ld_ready", ld_ready, 0);
        chk("t6_mem_we", mem_we, 0);
        chk("t6_cpu_run", cpu_run, 0);
        rst_n = 1;
        load_random(4, 0);
        q = {};
        q.push_back(8'd0); q.push_back(8'd1);
        fetch_burst(q, 1);
        repeat (3) tick();
        chk("write_queue_drained", exp_wr.size(), 0);
        chk("fetch_queue_drained", exp_fd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
